// File: rtl/capture_ctrl_pkg.sv
// Shared helpers for the capture controller: address-width derivation.
package capture_ctrl_pkg;

  // Number of bits needed to hold the value v (at least one bit).
  function automatic int log2bits(input int v);
    int n;
    int x;
    n = 0;
    x = v;
    while (x > 0) begin
      n++;
      x = x >> 1;
    end
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Triggered sample capture: arm, wait for a qualified trigger, then write
// NUM_SAMPLES consecutive valid samples into an external buffer.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int NUM_SAMPLES = 1024,
  parameter int DATA_WIDTH  = 16,
  localparam int AW         = log2bits(NUM_SAMPLES - 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SAMPLES - 1);

  state_t        state;
  logic [AW-1:0] cnt;

  // cnt is the index of the next sample; it stops at LAST_IDX so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state <= ARMED;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          ARMED, CAPTURE: begin
            if (in_valid && (trig || state == CAPTURE)) begin
              wr_en   <= 1'b1;
              wr_addr <= cnt;
              wr_data <= in_data;
              if (cnt == LAST_IDX) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= CAPTURE;
                cnt   <= cnt + AW'(1);
              end
            end
          end
          DONE: begin
            if (arm) begin
              state <= ARMED;
              cnt   <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
